// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, receiver FSM states
// and small helpers shared by the VGA generator and receiver.
package vga_timing_pkg;

  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_TOT  = H_SYNC + H_BP + H_ACT + H_FP;

  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_ACT  = 480;
  localparam int V_FP   = 10;
  localparam int V_TOT  = V_SYNC + V_BP + V_ACT + V_FP;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  function automatic logic [9:0] sat_inc10(
    input logic [9:0] v
  );
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registers one sync-domain input twice; emits level, rise, fall.
// Ports: clk_i, rst_ni, d_i -> lvl_o, rise_o, fall_o.
module vga_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s_q;
  logic d_q;

  // Reset to the idle level so release never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= RST_VAL;
      d_q <= RST_VAL;
    end else begin
      s_q <= d_i;
      d_q <= s_q;
    end
  end

  assign lvl_o  = s_q;
  assign rise_o = s_q & ~d_q;
  assign fall_o = ~s_q & d_q;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers row/col, checks geometry, reports lock.
// Ports: vga_clk, clrn, hs, vs, rdn -> row, col, pix_valid, locked, pulses.
module vga_sync_rx
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOT,
  parameter int V_TOTAL     = V_TOT,
  parameter int H_ACTIVE    = H_ACT,
  parameter int V_ACTIVE    = V_ACT,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       vga_clk,
  input  logic       clrn,
  input  logic       hs,
  input  logic       vs,
  input  logic       rdn,
  output logic [8:0] row,
  output logic [9:0] col,
  output logic       pix_valid,
  output logic       locked,
  output logic       frame_start,
  output logic       line_err,
  output logic       frame_err
);

  logic s_hs, s_vs, s_rdn;
  logic hs_rise, hs_fall;
  logic vs_rise, vs_fall;
  logic rdn_rise, rdn_fall;

  vga_edge_det u_hs (
    .clk_i (vga_clk),
    .rst_ni(clrn),
    .d_i   (hs),
    .lvl_o (s_hs),
    .rise_o(hs_rise),
    .fall_o(hs_fall)
  );

  vga_edge_det u_vs (
    .clk_i (vga_clk),
    .rst_ni(clrn),
    .d_i   (vs),
    .lvl_o (s_vs),
    .rise_o(vs_rise),
    .fall_o(vs_fall)
  );

  vga_edge_det u_rdn (
    .clk_i (vga_clk),
    .rst_ni(clrn),
    .d_i   (rdn),
    .lvl_o (s_rdn),
    .rise_o(rdn_rise),
    .fall_o(rdn_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{s_hs, s_vs, hs_fall, vs_fall};

  rx_state_e   state_q, state_d;
  logic [7:0]  ok_cnt_q, ok_cnt_d;
  logic        err_seen_q, err_seen_d;

  logic [9:0]  h_cnt_q;
  logic [9:0]  l_cnt_q;
  logic [9:0]  col_q;
  logic [8:0]  row_q;
  logic        first_hs_q;
  logic        frame_start_q;
  logic        line_err_q;
  logic        frame_err_q;
  logic        pix_valid_q;
  logic        pix_valid_d;

  logic        chk_en;
  logic        h_bad, w_bad;
  logic        l_bad, r_bad;
  logic [10:0] l_sum;
  logic        line_err_d;
  logic        frame_err_d;

  // A coincident hs rise is line 0 of the new
  // frame, so it still belongs to the old count.
  assign l_sum  = {1'b0, l_cnt_q}
                + {10'd0, hs_rise};
  assign chk_en = (state_q != SEARCH);

  // col holds run length minus one at rdn rise.
  assign h_bad = hs_rise && !first_hs_q
              && (h_cnt_q != 10'(H_TOTAL - 1));
  assign w_bad = rdn_rise
              && (col_q != 10'(H_ACTIVE - 1));
  assign l_bad = vs_rise
              && (l_sum != 11'(V_TOTAL));
  assign r_bad = vs_rise
              && (row_q != 9'(V_ACTIVE));

  assign line_err_d  = chk_en && (h_bad || w_bad);
  assign frame_err_d = chk_en && (l_bad || r_bad);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt_q       <= '0;
      l_cnt_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      first_hs_q    <= 1'b1;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
    end else begin
      h_cnt_q <= hs_rise ? '0 : sat_inc10(h_cnt_q);

      if (vs_rise)      l_cnt_q <= '0;
      else if (hs_rise) l_cnt_q <= sat_inc10(l_cnt_q);

      if (rdn_fall)    col_q <= '0;
      else if (!s_rdn) col_q <= sat_inc10(col_q);

      if (vs_rise)
        row_q <= '0;
      else if (rdn_rise && row_q != 9'h1ff)
        row_q <= row_q + 9'd1;

      // The hs period before tracking began
      // is not trusted.
      if (!chk_en)      first_hs_q <= 1'b1;
      else if (hs_rise) first_hs_q <= 1'b0;

      frame_start_q <= vs_rise;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      pix_valid_q   <= pix_valid_d;
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= SEARCH;
      ok_cnt_q   <= '0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ok_cnt_q   <= ok_cnt_d;
      err_seen_q <= err_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ok_cnt_d   = ok_cnt_q;
    err_seen_d = err_seen_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d    = TRACK;
          ok_cnt_d   = '0;
          err_seen_d = 1'b0;
        end
      end
      TRACK: begin
        if (line_err_d) err_seen_d = 1'b1;
        if (vs_rise) begin
          err_seen_d = 1'b0;
          if (err_seen_q || line_err_d
              || frame_err_d) begin
            ok_cnt_d = '0;
          end else begin
            ok_cnt_d = ok_cnt_q + 8'd1;
            if (ok_cnt_d == 8'(LOCK_FRAMES))
              state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        // Drop on the registered pulse so lock
        // falls one cycle after the error.
        if (line_err_q || frame_err_q)
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked      = (state_q == LOCKED);
    pix_valid_d = (state_q == LOCKED) && !s_rdn;
    pix_valid   = pix_valid_q && locked;
  end

  assign row         = row_q;
  assign col         = col_q;
  assign frame_start = frame_start_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a reduced 20x12 raster
// with injected line, run, row and frame faults.
module tb_vga_sync_rx;
  import vga_timing_pkg::*;

  localparam int HS  = 3;
  localparam int HBP = 4;
  localparam int HA  = 10;
  localparam int HFP = 3;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int HA0 = HS + HBP;
  localparam int VA0 = VS + VBP;

  logic       clk  = 1'b0;
  logic       clrn = 1'b1;
  logic       hs   = 1'b1;
  logic       vs   = 1'b1;
  logic       rdn  = 1'b1;
  logic [8:0] row;
  logic [9:0] col;
  logic       pix_valid, locked;
  logic       frame_start, line_err, frame_err;

  always #20 clk = ~clk;

  vga_sync_rx #(
    .H_TOTAL    (HT),
    .V_TOTAL    (VT),
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .LOCK_FRAMES(2)
  ) dut (
    .vga_clk    (clk),
    .clrn       (clrn),
    .hs         (hs),
    .vs         (vs),
    .rdn        (rdn),
    .row        (row),
    .col        (col),
    .pix_valid  (pix_valid),
    .locked     (locked),
    .frame_start(frame_start),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  int gh = 0, gv = 0, cyc = 0;
  int f_hline = -1, f_vlen = VT;
  int f_srun = -1, f_xrow = -1;
  int n_fs, n_le, n_fe, n_pv, pix_err, lock_at;
  int le_cyc, fe_cyc, unlock_cyc;
  int vs_cyc, short_cyc;
  int first_r, first_c, last_r, last_c;
  logic prev_lk;
  logic p0_act, p1_act;
  int p0_r, p0_c, p1_r, p1_c;

  task automatic clr();
    n_fs = 0; n_le = 0; n_fe = 0;
    n_pv = 0; pix_err = 0; lock_at = 0;
    le_cyc = -100; fe_cyc = -100;
    unlock_cyc = -100; vs_cyc = -100;
    short_cyc = -100;
    first_r = -1; first_c = -1;
    last_r = -1; last_c = -1;
    prev_lk = 1'b0;
    p0_act = 1'b0; p1_act = 1'b0;
  endtask

  task automatic tick();
    bit act;
    int hl, cr, cc;
    @(posedge clk); #1;
    cyc++;
    act = (gh >= HA0 && gh < HA0 + HA)
       && ((gv >= VA0 && gv < VA0 + VA)
           || gv == f_xrow);
    if (gv == f_srun && gh == HA0 + HA - 1) begin
      act = 1'b0;
      short_cyc = cyc;
    end
    hs  = (gh >= HS);
    vs  = (gv >= VS);
    rdn = !act;
    if (gv == VS && gh == 0) vs_cyc = cyc;
    cr = gv - VA0;
    cc = gh - HA0;
    hl = (gv == f_hline) ? HT - 1 : HT;
    if (gh == hl - 1) begin
      gh = 0;
      gv = (gv == f_vlen - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
    @(negedge clk);
    if (frame_start) begin
      n_fs++;
      if (locked && lock_at == 0) lock_at = n_fs;
    end
    if (line_err) begin
      n_le++;
      le_cyc = cyc;
    end
    if (frame_err) begin
      n_fe++;
      fe_cyc = cyc;
    end
    if (prev_lk && !locked) unlock_cyc = cyc;
    prev_lk = locked;
    if (pix_valid) begin
      if (n_pv == 0) begin
        first_r = int'(row);
        first_c = int'(col);
      end
      last_r = int'(row);
      last_c = int'(col);
      n_pv++;
      if (!p1_act || int'(row) != p1_r
          || int'(col) != p1_c)
        pix_err++;
    end
    p1_act = p0_act; p1_r = p0_r; p1_c = p0_c;
    p0_act = act;    p0_r = cr;   p0_c = cc;
  endtask

  task automatic run_to_frame_end();
    do tick(); while (!(gh == 0 && gv == 0));
  endtask

  task automatic run_frames(input int n);
    repeat (n) run_to_frame_end();
  endtask

  task automatic tick_until(input int v,
                            input int h);
    while (!(gv == v && gh == h)) tick();
  endtask

  task automatic idle_reset();
    @(negedge clk);
    clrn = 1'b0;
    hs = 1'b1; vs = 1'b1; rdn = 1'b1;
    gh = 0; gv = 0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    clr();
  endtask

  initial begin
    clr();
    #5 clrn = 1'b0;
    #1;
    chk("rst_flags", {locked, pix_valid,
        frame_start, line_err, frame_err}, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_state", int'(dut.state_q),
        int'(SEARCH));
    idle_reset();

    // Three clean frames from reset.
    run_frames(3);
    chk("a_fs", n_fs, 3);
    chk("a_lock_at", lock_at, 3);
    chk("a_locked", locked, 1);
    chk("a_npv", n_pv, HA * VA);
    chk("a_pix", pix_err, 0);
    chk("a_first", first_r * 1024 + first_c, 0);
    chk("a_last", last_r * 1024 + last_c,
        (VA - 1) * 1024 + HA - 1);
    chk("a_errs", n_le + n_fe, 0);

    // One short line while locked.
    clr();
    f_hline = VT - 2;
    run_to_frame_end();
    f_hline = -1;
    chk("b_le", n_le, 1);
    chk("b_unlock", unlock_cyc - le_cyc, 1);
    chk("b_locked", locked, 0);
    run_frames(2);
    chk("b_still", locked, 0);
    run_frames(1);
    chk("b_relock", locked, 1);
    chk("b_le_tot", n_le, 1);
    chk("b_fe", n_fe, 0);

    // Asynchronous reset mid-line while locked.
    clr();
    tick_until(VA0 + 1, HA0 + 5);
    chk("e_pre_pv", pix_valid, 1);
    chk("e_pre_col", col, 2);
    clrn = 1'b0;
    #1;
    chk("e_flags", {locked, pix_valid,
        frame_start, line_err, frame_err}, 0);
    chk("e_row", row, 0);
    chk("e_col", col, 0);
    chk("e_state", int'(dut.state_q),
        int'(SEARCH));
    repeat (3) tick();
    clrn = 1'b1;
    clr();
    run_to_frame_end();
    run_frames(3);
    chk("e_lock_at", lock_at, 3);
    chk("e_locked", locked, 1);

    // Frame one line short while tracking.
    idle_reset();
    f_vlen = VT - 1;
    run_to_frame_end();
    f_vlen = VT;
    tick_until(VA0 + 1, 0);
    chk("c_fe", n_fe, 1);
    chk("c_ok", dut.ok_cnt_q, 0);
    chk("c_state", int'(dut.state_q),
        int'(TRACK));
    run_to_frame_end();
    run_frames(2);
    chk("c_lock_at", lock_at, 4);
    chk("c_locked", locked, 1);
    chk("c_le", n_le, 0);

    // Short active run, then an extra row.
    clr();
    f_srun = VA0 + 1;
    run_to_frame_end();
    f_srun = -1;
    chk("d_le", n_le, 1);
    chk("d_le_lat", le_cyc - short_cyc, 2);
    chk("d_locked", locked, 0);
    clr();
    f_xrow = VA0 + VA;
    run_to_frame_end();
    f_xrow = -1;
    tick_until(VS + 1, 0);
    chk("d_fe", n_fe, 1);
    chk("d_fe_lat", fe_cyc - vs_cyc, 2);
    chk("d_fs", n_fs, 2);
    chk("d_le2", n_le, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
